// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_ctrl_pkg
//  Purpose  : Shared encodings for the multi-cycle RV32I control path: state
//             codes, opcode constants, ALU operation codes, immediate format
//             codes, datapath mux select codes and ALU decode classes.
//  Revision : 1.0 - initial release
// ============================================================================
package core_ctrl_pkg;

    // ---------------- controller state encoding ----------------
    typedef logic [3:0] state_t;

    localparam state_t c_st_fetch    = 4'd0;
    localparam state_t c_st_decode   = 4'd1;
    localparam state_t c_st_mem_addr = 4'd2;
    localparam state_t c_st_mem_rd   = 4'd3;
    localparam state_t c_st_mem_wb   = 4'd4;
    localparam state_t c_st_mem_wr   = 4'd5;
    localparam state_t c_st_exec_r   = 4'd6;
    localparam state_t c_st_exec_i   = 4'd7;
    localparam state_t c_st_alu_wb   = 4'd8;
    localparam state_t c_st_branch   = 4'd9;
    localparam state_t c_st_jal      = 4'd10;
    localparam state_t c_st_jalr     = 4'd11;
    localparam state_t c_st_lui      = 4'd12;
    localparam state_t c_st_halt     = 4'd13;

    // ---------------- opcodes (instr[6:0]) ----------------
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    // ---------------- ALU operation codes ----------------
    localparam logic [2:0] c_aluop_add  = 3'd0;
    localparam logic [2:0] c_aluop_sub  = 3'd1;
    localparam logic [2:0] c_aluop_and  = 3'd2;
    localparam logic [2:0] c_aluop_or   = 3'd3;
    localparam logic [2:0] c_aluop_xor  = 3'd4;
    localparam logic [2:0] c_aluop_slt  = 3'd5;
    localparam logic [2:0] c_aluop_sltu = 3'd6;

    // ---------------- immediate formats ----------------
    localparam logic [2:0] c_ext_i = 3'd0;
    localparam logic [2:0] c_ext_s = 3'd1;
    localparam logic [2:0] c_ext_b = 3'd2;
    localparam logic [2:0] c_ext_j = 3'd3;
    localparam logic [2:0] c_ext_u = 3'd4;

    // ---------------- datapath mux selects ----------------
    localparam logic [1:0] c_asel_pc     = 2'd0;
    localparam logic [1:0] c_asel_oldpc  = 2'd1;
    localparam logic [1:0] c_asel_rd1    = 2'd2;

    localparam logic [1:0] c_bsel_rd2    = 2'd0;
    localparam logic [1:0] c_bsel_imm    = 2'd1;
    localparam logic [1:0] c_bsel_four   = 2'd2;

    localparam logic [1:0] c_res_alureg  = 2'd0;
    localparam logic [1:0] c_res_mem     = 2'd1;
    localparam logic [1:0] c_res_aluout  = 2'd2;
    localparam logic [1:0] c_res_imm     = 2'd3;

    // ---------------- ALU decode classes ----------------
    localparam logic [1:0] c_cls_add   = 2'd0;  // address / PC arithmetic
    localparam logic [1:0] c_cls_sub   = 2'd1;  // branch compare
    localparam logic [1:0] c_cls_rtype = 2'd2;  // register-register op
    localparam logic [1:0] c_cls_itype = 2'd3;  // register-immediate op

    // Branch resolution from the RD1-RD2 flags; unsupported func3 never takes.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       zero_f,
                                          input logic       neg_f);
        logic taken;
        case (f3)
            3'b000:  taken = zero_f;    // beq
            3'b001:  taken = !zero_f;   // bne
            3'b100:  taken = neg_f;     // blt
            3'b101:  taken = !neg_f;    // bge
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Combinational ALU operation select from the controller's decode
//             class and the instruction function fields.
//  Ports    : op_class [1:0] in  - c_cls_* class of the current state
//             func3    [2:0] in  - instr[14:12]
//             func7    [6:0] in  - instr[31:25] (only bit 5 is meaningful)
//             aluop    [2:0] out - c_aluop_* code
//  Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
    import core_ctrl_pkg::*;
(
    input  logic [1:0] op_class,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [2:0] aluop
);

    // Only func7[5] selects SUB; the remaining bits are don't-care here.
    logic w_unused_func7;
    assign w_unused_func7 = ^{func7[6], func7[4:0]};

    always_comb begin
        aluop = c_aluop_add;
        case (op_class)
            c_cls_sub: aluop = c_aluop_sub;
            c_cls_rtype, c_cls_itype: begin
                case (func3)
                    // Immediate forms have no SUB: func7 is not an opcode field there.
                    3'b000:  aluop = (op_class == c_cls_rtype && func7[5]) ? c_aluop_sub
                                                                            : c_aluop_add;
                    3'b111:  aluop = c_aluop_and;
                    3'b110:  aluop = c_aluop_or;
                    3'b100:  aluop = c_aluop_xor;
                    3'b010:  aluop = c_aluop_slt;
                    3'b011:  aluop = c_aluop_sltu;
                    default: aluop = c_aluop_add;
                endcase
            end
            default: aluop = c_aluop_add;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multi_cycle_controller
//  Purpose  : Multi-cycle RV32I control FSM. Sequences fetch / decode /
//             address / execute / writeback over one shared memory and ALU
//             and produces every datapath select and enable.
//  Ports    : clk, rst (sync, active-low)
//             op[6:0], func3[2:0], func7[6:0]  - instruction fields
//             zero, neg                        - ALU flags (used in BRANCH)
//             pcwrite, adrsel, irwrite, wedata, wereg      - enables / selects
//             alusela[1:0], aluselb[1:0], aluop[2:0]       - ALU control
//             extend_func[2:0], resultsel[1:0]             - imm / result
//             instr_done, halted                           - status
//  Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_controller
    import core_ctrl_pkg::*;
#(
    parameter int MEM_LAT  = 0,     // extra wait cycles per memory access, 0..15
    parameter bit HALT_ILL = 1'b1   // 1: illegal opcode halts, 0: treated as NOP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       neg,
    output logic       pcwrite,
    output logic       adrsel,
    output logic       irwrite,
    output logic       wedata,
    output logic       wereg,
    output logic [1:0] alusela,
    output logic [1:0] aluselb,
    output logic [2:0] aluop,
    output logic [2:0] extend_func,
    output logic [1:0] resultsel,
    output logic       instr_done,
    output logic       halted
);

    localparam logic [3:0] c_mem_lat = 4'(MEM_LAT);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait;
    // Low for the first cycle after reset release: the controller idles in
    // FETCH with all outputs quiet before starting the first fetch.
    logic       r_live;

    logic       w_on;
    logic       w_wait_state;
    logic       w_wait_done;
    logic       w_count;
    logic [1:0] w_class;
    logic [2:0] w_dec_aluop;

    assign w_on         = rst && r_live;
    assign w_wait_state = (r_state == c_st_fetch)  ||
                          (r_state == c_st_mem_rd) ||
                          (r_state == c_st_mem_wr);
    assign w_wait_done  = (r_wait == c_mem_lat);
    assign w_count      = w_wait_state && r_live && !w_wait_done;

    // ---------------- state register and wait counter ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_fetch;
            r_wait  <= 4'd0;
            r_live  <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait <= 4'd0;
            end else if (w_count) begin
                r_wait <= r_wait + 4'd1;
            end
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_fetch:    if (r_live && w_wait_done) w_next = c_st_decode;
            c_st_decode: begin
                case (op)
                    c_op_load, c_op_store: w_next = c_st_mem_addr;
                    c_op_rtype:            w_next = c_st_exec_r;
                    c_op_itype:            w_next = c_st_exec_i;
                    c_op_branch:           w_next = c_st_branch;
                    c_op_jal:              w_next = c_st_jal;
                    c_op_jalr:             w_next = c_st_jalr;
                    c_op_lui:              w_next = c_st_lui;
                    default:               w_next = HALT_ILL ? c_st_halt : c_st_fetch;
                endcase
            end
            c_st_mem_addr: w_next = (op == c_op_store) ? c_st_mem_wr : c_st_mem_rd;
            c_st_mem_rd:   if (w_wait_done) w_next = c_st_mem_wb;
            c_st_mem_wb:   w_next = c_st_fetch;
            c_st_mem_wr:   if (w_wait_done) w_next = c_st_fetch;
            c_st_exec_r:   w_next = c_st_alu_wb;
            c_st_exec_i:   w_next = c_st_alu_wb;
            c_st_alu_wb:   w_next = c_st_fetch;
            c_st_branch:   w_next = c_st_fetch;
            c_st_jal:      w_next = c_st_alu_wb;
            c_st_jalr:     w_next = c_st_alu_wb;
            c_st_lui:      w_next = c_st_fetch;
            c_st_halt:     w_next = c_st_halt;
            default:       w_next = c_st_fetch;
        endcase
    end

    // ---------------- ALU operation decode ----------------
    always_comb begin
        w_class = c_cls_add;
        case (r_state)
            c_st_exec_r: w_class = c_cls_rtype;
            c_st_exec_i: w_class = c_cls_itype;
            c_st_branch: w_class = c_cls_sub;
            default:     w_class = c_cls_add;
        endcase
    end

    alu_decoder u_alu_decoder (
        .op_class (w_class),
        .func3    (func3),
        .func7    (func7),
        .aluop    (w_dec_aluop)
    );

    // ---------------- output decode ----------------
    // Everything is forced quiet while rst is low (so an aborted instruction
    // cannot write) and during the idle cycle after release.
    always_comb begin
        pcwrite     = 1'b0;
        adrsel      = 1'b0;
        irwrite     = 1'b0;
        wedata      = 1'b0;
        wereg       = 1'b0;
        alusela     = c_asel_pc;
        aluselb     = c_bsel_rd2;
        aluop       = c_aluop_add;
        extend_func = c_ext_i;
        resultsel   = c_res_alureg;
        instr_done  = 1'b0;
        halted      = 1'b0;
        if (w_on) begin
            case (r_state)
                c_st_fetch: begin
                    // PC+4 is computed every fetch cycle; IR and PC load once
                    // the memory has delivered the instruction.
                    alusela   = c_asel_pc;
                    aluselb   = c_bsel_four;
                    aluop     = w_dec_aluop;
                    resultsel = c_res_aluout;
                    irwrite   = w_wait_done;
                    pcwrite   = w_wait_done;
                end
                c_st_decode: begin
                    // Branch target precomputed here, consumed by BRANCH.
                    alusela     = c_asel_oldpc;
                    aluselb     = c_bsel_imm;
                    aluop       = w_dec_aluop;
                    extend_func = c_ext_b;
                end
                c_st_mem_addr: begin
                    alusela     = c_asel_rd1;
                    aluselb     = c_bsel_imm;
                    aluop       = w_dec_aluop;
                    extend_func = (op == c_op_store) ? c_ext_s : c_ext_i;
                end
                c_st_mem_rd: begin
                    adrsel = 1'b1;
                end
                c_st_mem_wb: begin
                    resultsel  = c_res_mem;
                    wereg      = 1'b1;
                    instr_done = 1'b1;
                end
                c_st_mem_wr: begin
                    adrsel     = 1'b1;
                    wedata     = w_wait_done;
                    instr_done = w_wait_done;
                end
                c_st_exec_r: begin
                    alusela = c_asel_rd1;
                    aluselb = c_bsel_rd2;
                    aluop   = w_dec_aluop;
                end
                c_st_exec_i: begin
                    alusela     = c_asel_rd1;
                    aluselb     = c_bsel_imm;
                    aluop       = w_dec_aluop;
                    extend_func = c_ext_i;
                end
                c_st_alu_wb: begin
                    resultsel  = c_res_alureg;
                    wereg      = 1'b1;
                    instr_done = 1'b1;
                end
                c_st_branch: begin
                    alusela    = c_asel_rd1;
                    aluselb    = c_bsel_rd2;
                    aluop      = w_dec_aluop;
                    resultsel  = c_res_alureg;
                    pcwrite    = branch_taken(func3, zero, neg);
                    instr_done = 1'b1;
                end
                c_st_jal: begin
                    alusela     = c_asel_oldpc;
                    aluselb     = c_bsel_imm;
                    aluop       = w_dec_aluop;
                    extend_func = c_ext_j;
                    resultsel   = c_res_aluout;
                    pcwrite     = 1'b1;
                end
                c_st_jalr: begin
                    // The datapath clears bit 0 of the jump target.
                    alusela     = c_asel_rd1;
                    aluselb     = c_bsel_imm;
                    aluop       = w_dec_aluop;
                    extend_func = c_ext_i;
                    resultsel   = c_res_aluout;
                    pcwrite     = 1'b1;
                end
                c_st_lui: begin
                    extend_func = c_ext_u;
                    resultsel   = c_res_imm;
                    wereg       = 1'b1;
                    instr_done  = 1'b1;
                end
                c_st_halt: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
